mmio_uart_tx: RTL and testbench

Memory-mapped serial output port downstream of the `rv32i` + `mem` top. It watches the core's data-side store bus (write strobe, 16-bit address, 32-bit write data). A store to one fixed address queues the low byte in a small FIFO. An 8N1 UART transmitter drains the FIFO onto a single `tx` line, so firmware output can be seen on a pin instead of only on the raw bus outputs.

---
 rtl/mmio_uart_tx.sv | 175 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Purpose: MMIO store snooper that queues the low byte of stores to TX_ADDR and transmits it as UART 8N1 (8E1 with parity).
// Latency: a store accepted at edge N is popped at edge N+1 when idle, so the start bit begins then; frames run back to back.
// Backpressure: none toward the core; a store that finds the FIFO full with no pop in the same cycle is dropped and sets sticky overflow.
//
// Ports: clk/rst (sync, active-high); we/address/write_data = core store bus;
//        tx = serial line (idle high); busy = frame active or bytes queued;
//        overflow = sticky drop flag; fifo_count = queued byte count.
// Build option: define MMIO_UART_TX_PARITY_EN to add an even-parity bit (11-bit frames).
module mmio_uart_tx #(
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] TX_ADDR    = 16'hFF00
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [15:0]                   address,
  input  logic [31:0]                   write_data,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [PW:0]   DEPTH_C  = (PW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [2:0]    state;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    tx_byte;
  logic [7:0]    head;

  logic push_req;
  logic push_acc;
  logic pop;
  logic bit_done;
  logic fifo_nonempty;

  // Upper store bits are architecturally ignored.
  logic unused_hi;
  assign unused_hi = ^write_data[31:8];

  assign push_req      = we && (address == TX_ADDR);
  assign fifo_nonempty = (fifo_count != '0);
  assign bit_done      = (tick_cnt == '0);
  // Pops happen only from IDLE or on the final STOP cycle, so the next
  // frame starts on the very next cycle with no idle gap.
  assign pop           = fifo_nonempty && ((state == IDLE) || ((state == STOP) && bit_done));
  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign push_acc      = push_req && ((fifo_count != DEPTH_C) || pop);
  assign head          = mem[rd_ptr];
  assign busy          = (state != IDLE) || fifo_nonempty;

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      mem[wr_ptr] <= write_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      case ({push_acc, pop})
        2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push_req && !push_acc) overflow <= 1'b1;
    end
  end

  // tx is registered and updated on the same edge as each state/bit entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tick_cnt <= '0;
      bit_idx  <= '0;
      tx_byte  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            tx_byte  <= head;
            state    <= START;
            tx       <= 1'b0;
            tick_cnt <= DIV_LAST;
          end
        end
        START: begin
          if (bit_done) begin
            state    <= DATA;
            bit_idx  <= '0;
            tx       <= tx_byte[0];
            tick_cnt <= DIV_LAST;
          end else begin
            tick_cnt <= tick_cnt - CW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            tick_cnt <= DIV_LAST;
            if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= ^tx_byte;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= tx_byte[bit_idx + 3'd1];
            end
          end else begin
            tick_cnt <= tick_cnt - CW'(1);
          end
        end
`ifdef MMIO_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state    <= STOP;
            tx       <= 1'b1;
            tick_cnt <= DIV_LAST;
          end else begin
            tick_cnt <= tick_cnt - CW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            if (pop) begin
              tx_byte  <= head;
              state    <= START;
              tx       <= 1'b0;
              tick_cnt <= DIV_LAST;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam int          CLK_DIV    = 4;
  localparam int          FIFO_DEPTH = 8;
  localparam logic [15:0] TX_ADDR    = 16'hFF00;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_LEN = NBITS * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [15:0] address;
  logic [31:0] write_data;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [3:0]  fifo_count;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [7:0] sb_q[$];
  int         start_q[$];
  bit         mon_en = 1'b0;

  mmio_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TX_ADDR    (TX_ADDR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .address    (address),
    .write_data (write_data),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive at posedge+1, let one edge pass, release the strobe.
  task automatic bus_cycle(input logic w, input logic [15:0] a, input logic [31:0] d);
    we = w; address = a; write_data = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic store_byte(input logic [31:0] d);
    sb_q.push_back(d[7:0]);
    bus_cycle(1'b1, TX_ADDR, d);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_in_time", 32'(n < 5000), 1);
    chk("drain_fifo_count", fifo_count, 0);
    chk("drain_tx_idle", tx, 1);
  endtask

  // Monitor: decodes the serial line by mid-bit sampling and checks each
  // frame against the oldest byte the stimulus expects.
  initial begin
    int         m_cyc;
    int         k;
    bit         m_active;
    logic [7:0] m_byte;
    logic [7:0] exp_b;
    logic       m_par;
    m_active = 1'b0;
    m_cyc = 0;
    m_byte = '0;
    m_par = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        if (tx === 1'b0) begin
          m_active = 1'b1;
          m_cyc = 0;
          m_byte = '0;
          start_q.push_back(cyc);
        end
      end else begin
        m_cyc++;
        if (m_cyc >= CLK_DIV/2 && ((m_cyc - CLK_DIV/2) % CLK_DIV) == 0) begin
          k = (m_cyc - CLK_DIV/2) / CLK_DIV;
          if (k == 0) begin
            chk("start_bit", tx, 0);
          end else if (k <= 8) begin
            m_byte[k-1] = tx;
          end else if (k < NBITS - 1) begin
            m_par = tx;
          end else begin
            chk("stop_bit", tx, 1);
            checks++;
            if (sb_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_frame: got byte 0x%0h expected no frame", m_byte);
            end else begin
              exp_b = sb_q.pop_front();
              if (m_byte !== exp_b) begin
                errors++;
                $display("FAIL frame_byte: got 0x%0h expected 0x%0h", m_byte, exp_b);
              end
`ifdef MMIO_UART_TX_PARITY_EN
              chk("parity_bit", m_par, ^exp_b);
`endif
            end
            m_active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int n;
    int r;
    logic [15:0] a;
    logic        w;
    rst = 1'b1; we = 1'b0; address = '0; write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_fifo_count", fifo_count, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Single byte: start bit one edge after the store, busy spans one frame.
    store_byte(32'h1234_5A41);
    chk("single_count_after_store", fifo_count, 1);
    chk("single_tx_before_pop", tx, 1);
    @(posedge clk); #1;
    chk("single_tx_start", tx, 0);
    chk("single_count_after_pop", fifo_count, 0);
    chk("single_busy", busy, 1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 200);
    chk("single_busy_len", n, FRAME_LEN);
    drain();

    // Address filter.
    bus_cycle(1'b1, 16'hFF04, 32'h0000_0055);
    chk("filter_ff04", fifo_count, 0);
    bus_cycle(1'b1, 16'h0000, 32'h0000_0066);
    chk("filter_0000", fifo_count, 0);
    bus_cycle(1'b0, TX_ADDR, 32'h0000_0077);
    chk("filter_no_we", fifo_count, 0);
    chk("filter_tx", tx, 1);
    chk("filter_busy", busy, 0);

    // Overflow: 00 popped on the first idle edge, 01..08 fill, 09 dropped.
    for (int i = 0; i < 10; i++) begin
      if (i < 9) store_byte(32'(i));
      else       bus_cycle(1'b1, TX_ADDR, 32'(i));
      if (i == 8) chk("ovf_not_yet", overflow, 0);
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_count_full", fifo_count, FIFO_DEPTH);
    drain();
    chk("ovf_sticky", overflow, 1);

    // Back-to-back frames.
    start_q.delete();
    store_byte(32'h0000_00A5);
    store_byte(32'h0000_003C);
    drain();
    chk("b2b_frames", start_q.size(), 2);
    if (start_q.size() == 2) chk("b2b_gap", start_q[1] - start_q[0], FRAME_LEN);

    // Reset during data bit 3 of 8'hC3 (bit 3 = 0); also a store during reset.
    mon_en = 1'b0;
    bus_cycle(1'b1, TX_ADDR, 32'h0000_00C3);
    repeat (4*CLK_DIV + 2) @(posedge clk);
    #1;
    chk("midframe_busy", busy, 1);
    chk("midframe_bit3", tx, 0);
    rst = 1'b1;
    we = 1'b1; address = TX_ADDR; write_data = 32'h0000_0099;
    @(posedge clk); #1;
    we = 1'b0;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_push_ignored", fifo_count, 0);
    mon_en = 1'b1;
    store_byte(32'h0000_005A);
    store_byte(32'h0000_0007);
    drain();

    // Randomized traffic with bus noise; real stores only when the model has room.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      r = $urandom_range(0, 3);
      if (r == 0) begin
        a = 16'($urandom);
        w = 1'($urandom);
        if (w && a == TX_ADDR) a = 16'hFF04;
        bus_cycle(w, a, $urandom);
      end else if (sb_q.size() < FIFO_DEPTH) begin
        store_byte($urandom);
      end else begin
        @(posedge clk); #1;
      end
    end
    drain();
    chk("final_overflow", overflow, 0);
    chk("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
